// File: rtl/arbitro_escritura_registros_if.sv
// rtl/arbitro_escritura_registros_if.sv - requester/register-file bus shared by the write-port arbiter
interface arbitro_escritura_registros_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int NREG  = 2 ** ADDR_W;

  // requester A: ALU writeback, unbuffered
  logic              a_valid;
  logic              a_ready;
  logic [ADDR_W-1:0] a_reg;
  logic [DATA_W-1:0] a_data;

  // requester B: load-unit writeback, queued
  logic              b_valid;
  logic              b_ready;
  logic [ADDR_W-1:0] b_reg;
  logic [DATA_W-1:0] b_data;

  // register file write port and scoreboard
  logic [ADDR_W-1:0] writeReg;
  logic [DATA_W-1:0] writeData;
  logic              RegWrite;
  logic [NREG-1:0]   busy_mask;
  logic [CNT_W-1:0]  q_count;

  modport master (
    output a_valid, a_reg, a_data, b_valid, b_reg, b_data,
    input  a_ready, b_ready, writeReg, writeData, RegWrite, busy_mask, q_count
  );

  modport slave (
    input  a_valid, a_reg, a_data, b_valid, b_reg, b_data,
    output a_ready, b_ready, writeReg, writeData, RegWrite, busy_mask, q_count
  );
endinterface

// File: rtl/arbitro_escritura_registros.sv
// rtl/arbitro_escritura_registros.sv - single write-port arbiter with B FIFO, starvation guard and busy scoreboard
module arbitro_escritura_registros #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 3
) (
  input logic                      CLK,
  input logic                      RST,
  arbitro_escritura_registros_if.slave bus
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam int NREG   = 2 ** ADDR_W;

  // B queue storage, pointers and occupancy
  logic [ADDR_W-1:0] q_reg  [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [WAIT_W-1:0] wait_cnt;

  // registered write port towards the register file
  logic [ADDR_W-1:0] out_reg;
  logic [DATA_W-1:0] out_data;
  logic              out_we;

  logic              q_empty;
  logic              q_full;
  logic              starve;
  logic              enq;
  logic              issue_a;
  logic              deq;
  logic              issue;
  logic [ADDR_W-1:0] sel_reg;
  logic [DATA_W-1:0] sel_data;
  logic [NREG-1:0]   busy;
  logic [PTR_W-1:0]  scan_idx;

  assign q_empty = (count == '0);
  assign q_full  = (count == CNT_W'(DEPTH));
  assign starve  = (wait_cnt == WAIT_W'(MAX_WAIT));

  // A only loses the port when the queue head has waited too long
  assign issue_a = bus.a_valid & ~starve;
  assign deq     = ~issue_a & ~q_empty;
  assign issue   = issue_a | deq;
  // a full queue refuses even when it drains this cycle, keeping b_ready register-only
  assign enq     = bus.b_valid & ~q_full;

  assign bus.a_ready   = ~starve;
  assign bus.b_ready   = ~q_full;
  assign bus.writeReg  = out_reg;
  assign bus.writeData = out_data;
  assign bus.RegWrite  = out_we;
  assign bus.busy_mask = busy;
  assign bus.q_count   = count;

  // choose the write that owns the port this cycle
  always_comb begin
    sel_reg  = bus.a_reg;
    sel_data = bus.a_data;
    if (!issue_a) begin
      sel_reg  = q_reg[rd_ptr];
      sel_data = q_data[rd_ptr];
    end
  end

  // queue payload needs no reset: occupancy alone decides which slots are live
  always_ff @(posedge CLK) begin
    if (enq) begin
      q_reg[wr_ptr]  <= bus.b_reg;
      q_data[wr_ptr] <= bus.b_data;
    end
  end

  // pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // consecutive cycles the queue head has been passed over, saturating at MAX_WAIT
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wait_cnt <= '0;
    end else if (q_empty || deq) begin
      wait_cnt <= '0;
    end else if (!starve) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // one-cycle registered write; x0 still consumes its issue slot but never pulses RegWrite
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_reg  <= '0;
      out_data <= '0;
      out_we   <= 1'b0;
    end else if (issue) begin
      out_reg  <= sel_reg;
      out_data <= sel_data;
      out_we   <= (sel_reg != '0);
    end else begin
      out_we   <= 1'b0;
    end
  end

  // scoreboard built from live queue slots plus the write sitting in the output register
  always_comb begin
    busy     = '0;
    scan_idx = rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = rd_ptr + PTR_W'(i);
      if (CNT_W'(i) < count) busy[q_reg[scan_idx]] = 1'b1;
    end
    if (out_we) busy[out_reg] = 1'b1;
    busy[0] = 1'b0;
  end
endmodule

// File: tb/tb_arbitro_escritura_registros.sv
// tb/tb_arbitro_escritura_registros.sv - directed and random checks of the write-port arbiter against a queue model
module tb_arbitro_escritura_registros;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int DEPTH    = 4;
  localparam int MAX_WAIT = 3;

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } wr_t;

  logic CLK = 1'b0;
  logic RST;

  arbitro_escritura_registros_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

  arbitro_escritura_registros #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  // reference model state
  wr_t         mq[$];
  int          m_wait;
  logic        m_rw;
  logic [4:0]  m_reg;
  logic [31:0] m_data;
  logic        last_a_fire;
  logic        last_b_fire;
  logic [31:0] dut_rf [32];
  logic [31:0] saved [3];
  int          b_log[$];
  logic        log_en;
  int          n_checks;
  int          n_fail;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m;
    m = '0;
    foreach (mq[i]) m[mq[i].r] = 1'b1;
    if (m_rw) m[m_reg] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_wait = 0;
    m_rw   = 1'b0;
    m_reg  = '0;
    m_data = '0;
  endtask

  task automatic idle_inputs();
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
  endtask

  // one clock: check ready outputs, advance the model, then check registered outputs
  task automatic cycle();
    logic starve, a_fire, b_fire, had_q, popped, issued;
    wr_t  iss;
    starve = (m_wait == MAX_WAIT);
    chk("a_ready", 64'(bus.a_ready), 64'(!starve));
    chk("b_ready", 64'(bus.b_ready), 64'(mq.size() != DEPTH));
    a_fire = bus.a_valid && !starve;
    b_fire = bus.b_valid && (mq.size() != DEPTH);
    had_q  = (mq.size() != 0);
    popped = 1'b0;
    issued = 1'b0;
    iss    = '0;
    if (a_fire) begin
      iss.r  = bus.a_reg;
      iss.d  = bus.a_data;
      issued = 1'b1;
    end else if (had_q) begin
      iss    = mq.pop_front();
      issued = 1'b1;
      popped = 1'b1;
    end
    if (!had_q || popped) m_wait = 0;
    else if (m_wait < MAX_WAIT) m_wait++;
    if (b_fire) begin
      wr_t e;
      e.r = bus.b_reg;
      e.d = bus.b_data;
      mq.push_back(e);
    end
    m_rw = issued && (iss.r != 0);
    if (issued) begin
      m_reg  = iss.r;
      m_data = iss.d;
    end
    last_a_fire = a_fire;
    last_b_fire = b_fire;
    @(posedge CLK);
    #1;
    chk("RegWrite", 64'(bus.RegWrite), 64'(m_rw));
    if (m_rw) begin
      chk("writeReg", 64'(bus.writeReg), 64'(m_reg));
      chk("writeData", 64'(bus.writeData), 64'(m_data));
    end
    chk("q_count", 64'(bus.q_count), 64'(mq.size()));
    chk("busy_mask", 64'(bus.busy_mask), 64'(model_mask()));
    if (bus.RegWrite === 1'b1) begin
      dut_rf[bus.writeReg] = bus.writeData;
      if (log_en && bus.writeReg >= 5'd1 && bus.writeReg <= 5'd4) b_log.push_back(int'(bus.writeReg));
    end
    @(negedge CLK);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    log_en   = 1'b0;
    last_a_fire = 1'b0;
    last_b_fire = 1'b0;
    foreach (dut_rf[i]) dut_rf[i] = '0;
    model_reset();
    RST = 1'b1;
    bus.a_valid = 1'b0; bus.a_reg = '0; bus.a_data = '0;
    bus.b_valid = 1'b0; bus.b_reg = '0; bus.b_data = '0;
    @(negedge CLK);
    @(negedge CLK);

    // reset state
    chk("rst RegWrite", 64'(bus.RegWrite), 64'(0));
    chk("rst writeReg", 64'(bus.writeReg), 64'(0));
    chk("rst writeData", 64'(bus.writeData), 64'(0));
    chk("rst q_count", 64'(bus.q_count), 64'(0));
    chk("rst busy_mask", 64'(bus.busy_mask), 64'(0));
    chk("rst b_ready", 64'(bus.b_ready), 64'(1));
    RST = 1'b0;

    // A-only stream
    bus.a_valid = 1'b1; bus.a_reg = 5'd5; bus.a_data = 32'h1111;
    chk("t2 a_ready0", 64'(bus.a_ready), 64'(1));
    cycle();
    chk("t2 first write", 64'({bus.RegWrite, bus.writeReg, bus.writeData}), 64'({1'b1, 5'd5, 32'h1111}));
    bus.a_reg = 5'd6; bus.a_data = 32'h2222;
    chk("t2 a_ready1", 64'(bus.a_ready), 64'(1));
    cycle();
    chk("t2 second write", 64'({bus.RegWrite, bus.writeReg, bus.writeData}), 64'({1'b1, 5'd6, 32'h2222}));
    idle_inputs();
    cycle();
    chk("t2 rf x5", 64'(dut_rf[5]), 64'(32'h1111));
    chk("t2 rf x6", 64'(dut_rf[6]), 64'(32'h2222));

    // starvation guard
    bus.b_valid = 1'b1; bus.b_reg = 5'd10; bus.b_data = 32'hBEEF;
    cycle();
    bus.b_valid = 1'b0;
    bus.a_valid = 1'b1; bus.a_reg = 5'd25;
    for (int k = 0; k < 3; k++) begin
      bus.a_data = $urandom;
      chk("t3 a served", 64'(bus.a_ready), 64'(1));
      cycle();
    end
    chk("t3 a blocked", 64'(bus.a_ready), 64'(0));
    cycle();
    chk("t3 b write", 64'({bus.RegWrite, bus.writeReg, bus.writeData}), 64'({1'b1, 5'd10, 32'hBEEF}));
    chk("t3 a resumes", 64'(bus.a_ready), 64'(1));
    cycle();
    chk("t3 a after", 64'(bus.writeReg), 64'(25));
    idle_inputs();
    cycle();

    // queue full with A hogging the port
    log_en = 1'b1;
    bus.a_valid = 1'b1; bus.a_reg = 5'd25;
    for (int i = 1; i <= 4; i++) begin
      bus.b_valid = 1'b1; bus.b_reg = 5'(i); bus.b_data = 32'(i * 256);
      bus.a_data = $urandom;
      cycle();
      chk("t4 enq", 64'(last_b_fire), 64'(1));
    end
    chk("t4 full count", 64'(bus.q_count), 64'(4));
    chk("t4 full ready", 64'(bus.b_ready), 64'(0));
    bus.b_reg = 5'd7; bus.b_data = 32'h7777;
    cycle();
    chk("t4 full reject", 64'(last_b_fire), 64'(0));
    for (int t = 0; t < 8 && !last_b_fire; t++) cycle();
    chk("t4 fifth accepted", 64'(last_b_fire), 64'(1));
    idle_inputs();
    for (int t = 0; t < 8; t++) cycle();
    log_en = 1'b0;
    chk("t4 order count", 64'(b_log.size()), 64'(4));
    for (int i = 0; i < 4; i++) begin
      if (i < b_log.size()) chk("t4 order", 64'(b_log[i]), 64'(i + 1));
    end

    // x0 filter
    bus.a_valid = 1'b1; bus.a_reg = 5'd0; bus.a_data = 32'hFFFF;
    cycle();
    chk("t5 a x0 fire", 64'(last_a_fire), 64'(1));
    chk("t5 a x0 no write", 64'(bus.RegWrite), 64'(0));
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b1; bus.b_reg = 5'd0; bus.b_data = 32'h1234;
    cycle();
    chk("t5 b x0 fire", 64'(last_b_fire), 64'(1));
    chk("t5 b x0 slot", 64'(bus.q_count), 64'(1));
    bus.b_valid = 1'b0;
    cycle();
    chk("t5 b x0 no write", 64'(bus.RegWrite), 64'(0));
    chk("t5 busy0", 64'(bus.busy_mask[0]), 64'(0));
    chk("t5 rf x0", 64'(dut_rf[0]), 64'(0));

    // scoreboard window for a queued write
    bus.b_valid = 1'b1; bus.b_reg = 5'd20; bus.b_data = $urandom;
    cycle();
    chk("t6 busy queued", 64'(bus.busy_mask[20]), 64'(1));
    bus.b_valid = 1'b0;
    cycle();
    chk("t6 busy writing", 64'({bus.busy_mask[20], bus.RegWrite, bus.writeReg}), 64'({1'b1, 1'b1, 5'd20}));
    cycle();
    chk("t6 busy clear", 64'(bus.busy_mask[20]), 64'(0));

    // reset mid-operation
    for (int i = 0; i < 3; i++) begin
      bus.a_valid = 1'b1; bus.a_reg = 5'(11 + i); bus.a_data = 32'hA110 + 32'(i);
      cycle();
    end
    idle_inputs();
    cycle();
    for (int i = 0; i < 3; i++) saved[i] = dut_rf[11 + i];
    chk("t1 prior x11", 64'(saved[0]), 64'(32'hA110));
    bus.a_valid = 1'b1; bus.a_reg = 5'd25;
    for (int i = 0; i < 3; i++) begin
      bus.b_valid = 1'b1; bus.b_reg = 5'(11 + i); bus.b_data = 32'hD000 + 32'(i);
      bus.a_data = $urandom;
      cycle();
    end
    idle_inputs();
    chk("t1 queued", 64'(bus.q_count), 64'(3));
    #2 RST = 1'b1;
    #1;
    chk("t1 q_count", 64'(bus.q_count), 64'(0));
    chk("t1 busy_mask", 64'(bus.busy_mask), 64'(0));
    chk("t1 RegWrite", 64'(bus.RegWrite), 64'(0));
    model_reset();
    @(negedge CLK);
    RST = 1'b0;
    for (int t = 0; t < 3; t++) cycle();
    for (int i = 0; i < 3; i++) chk("t1 rf kept", 64'(dut_rf[11 + i]), 64'(saved[i]));

    // random traffic
    for (int t = 0; t < 300; t++) begin
      bus.a_valid = ($urandom_range(0, 99) < 60);
      bus.a_reg   = 5'($urandom);
      bus.a_data  = $urandom;
      bus.b_valid = ($urandom_range(0, 99) < 50);
      bus.b_reg   = 5'($urandom);
      bus.b_data  = $urandom;
      cycle();
    end
    idle_inputs();
    for (int t = 0; t < 8; t++) cycle();
    chk("drained", 64'(bus.q_count), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
